fpga_serial_programmer: RTL and testbench

//  Parametrised FPGA-side configuration master for the mixed-signal chip. On i_start it resets
//  the chip, shifts a DATA_W-bit config word out on o_sclk/o_sdout, then waits for i_ready.
//  If i_ready does not arrive in time, it re-resets and re-programs the chip, up to MAX_RETRY times.

---
 rtl/fpga_serial_programmer_if.sv | 36 +++
 rtl/fpga_serial_programmer.sv | 198 +++++++++++++++++++
 tb/tb_fpga_serial_programmer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_serial_programmer_if.sv
// Purpose : Bundles the request/status and chip-side serial signals of the
//           FPGA serial configuration master into one interface.
// Signals : i_start     - programming request
//           i_cfgword   - configuration word (DATA_W bits)
//           i_ready     - chip ready, asynchronous to the main clock
//           o_resetbAll - chip reset, active low
//           o_sclk      - serial clock to the chip, idles high
//           o_sdout     - serial data to the chip
//           o_busy      - programming attempt in progress
//           o_done      - chip reported ready
//           o_error     - all attempts timed out
// Modports: master - the programmer (drives o_*, reads i_*)
//           slave  - the requester / chip side (drives i_*, reads o_*)
interface fpga_serial_programmer_if #(
  parameter int DATA_W = 16
);
  logic              i_start;
  logic [DATA_W-1:0] i_cfgword;
  logic              i_ready;
  logic              o_resetbAll;
  logic              o_sclk;
  logic              o_sdout;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  modport master (
    input  i_start, i_cfgword, i_ready,
    output o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_error
  );

  modport slave (
    output i_start, i_cfgword, i_ready,
    input  o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_error
  );
endinterface

// File: rtl/fpga_serial_programmer.sv
// Purpose : FPGA-side configuration master for the mixed-signal chip. On a
//           start request it holds the chip in reset, shifts a DATA_W-bit
//           word out on sclk/sdout, then waits for the chip's ready flag.
//           A missing ready re-resets and re-programs the chip up to
//           MAX_RETRY extra times before reporting an error. Everything runs
//           on i_mainclk; sclk is a registered output toggled by a counter.
// Ports   : i_mainclk   - main clock, rising edge
//           i_resetFPGA - asynchronous active-high reset
//           bus         - fpga_serial_programmer_if.master (request, status
//                         and chip-side serial signals)
module fpga_serial_programmer #(
  parameter int DATA_W     = 16,
  parameter int HALF_PER   = 8,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 3,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                      i_mainclk,
  input  logic                      i_resetFPGA,
  fpga_serial_programmer_if.master  bus
);

  // One counter is shared by the reset hold, the sclk phase and the WAIT timer,
  // so it is sized for the longest of the three.
  localparam int PHASE_LEN = 2 * HALF_PER;
  localparam int CNT_MAX_A = (RST_CYCLES > PHASE_LEN) ? RST_CYCLES : PHASE_LEN;
  localparam int CNT_MAX   = (TIMEOUT > CNT_MAX_A) ? TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SHIFT,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              sdout_q, sdout_d;
  logic              resetb_q, resetb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              readyMeta_q, readySync_q;

  // Serial position to word bit, honouring the shift order.
  function automatic logic pickBit(input logic [DATA_W-1:0] w, input logic [BIT_W-1:0] idx);
    if (MSB_FIRST) return w[DATA_W - 1 - int'(idx)];
    else           return w[idx];
  endfunction

  // Two-flop synchroniser for the chip's ready flag.
  always_ff @(posedge i_mainclk or posedge i_resetFPGA) begin
    if (i_resetFPGA) begin
      readyMeta_q <= 1'b0;
      readySync_q <= 1'b0;
    end else begin
      readyMeta_q <= bus.i_ready;
      readySync_q <= readyMeta_q;
    end
  end

  always_ff @(posedge i_mainclk or posedge i_resetFPGA) begin
    if (i_resetFPGA) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      retry_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b1;
      sdout_q  <= 1'b0;
      resetb_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      sdout_q  <= sdout_d;
      resetb_q <= resetb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Outputs are registered, so every output is computed here from the state
  // being entered rather than from the current one.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sclk_d  = 1'b1;
    sdout_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.i_start) begin
          state_d = S_RESET;
          word_d  = bus.i_cfgword;
          retry_d = '0;
          cnt_d   = '0;
        end
      end

      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          // First low half of sclk starts together with the first data bit.
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          sdout_d = pickBit(word_q, '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        sclk_d  = sclk_q;
        sdout_d = sdout_q;
        if (cnt_q == HALF_LAST) begin
          sclk_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end else if (cnt_q == PHASE_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_WAIT;
            sclk_d  = 1'b1;
            sdout_d = 1'b0;
          end else begin
            // Data only moves on a falling sclk edge.
            bit_d   = bit_q + 1'b1;
            sclk_d  = 1'b0;
            sdout_d = pickBit(word_q, bit_q + 1'b1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (readySync_q) begin
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d = '0;
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            state_d = S_RESET;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    resetb_d = (state_d != S_RESET);
    busy_d   = (state_d == S_RESET) || (state_d == S_SHIFT) || (state_d == S_WAIT);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERROR);
  end

  assign bus.o_resetbAll = resetb_q;
  assign bus.o_sclk      = sclk_q;
  assign bus.o_sdout     = sdout_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_error     = error_q;

endmodule

// File: tb/tb_fpga_serial_programmer.sv
// Purpose : Self-checking bench for fpga_serial_programmer. Two instances share
//           the clock and reset: uA shifts MSB first with two retries, uB shifts
//           LSB first with no retry. Monitors record what the chip would see
//           (bits sampled on rising sclk, reset-low run lengths, busy cycles);
//           the directed sequence compares those against words and durations
//           derived from the protocol rules.
module tb_fpga_serial_programmer;

  localparam int W      = 16;
  localparam int HP     = 2;
  localparam int RSTC   = 4;
  localparam int TO     = 20;
  localparam int RETRYA = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fpga_serial_programmer_if #(.DATA_W(W)) ifA ();
  fpga_serial_programmer_if #(.DATA_W(W)) ifB ();

  fpga_serial_programmer #(
    .DATA_W(W), .HALF_PER(HP), .RST_CYCLES(RSTC), .TIMEOUT(TO),
    .MAX_RETRY(RETRYA), .MSB_FIRST(1'b1)
  ) uA (
    .i_mainclk(clk),
    .i_resetFPGA(rst),
    .bus(ifA.master)
  );

  fpga_serial_programmer #(
    .DATA_W(W), .HALF_PER(HP), .RST_CYCLES(RSTC), .TIMEOUT(TO),
    .MAX_RETRY(0), .MSB_FIRST(1'b0)
  ) uB (
    .i_mainclk(clk),
    .i_resetFPGA(rst),
    .bus(ifB.master)
  );

  bit   capA[$];
  bit   capB[$];
  int   rstRunsA[$];
  int   lowRunA  = 0;
  int   busyCycA = 0;
  logic prevSclkA = 1'b1;
  logic prevSclkB = 1'b1;

  // Chip-eye view of both serial links, sampled on the falling main-clock edge.
  always @(negedge clk) begin
    if (prevSclkA == 1'b0 && ifA.o_sclk == 1'b1) capA.push_back(ifA.o_sdout);
    if (prevSclkB == 1'b0 && ifB.o_sclk == 1'b1) capB.push_back(ifB.o_sdout);
    if (!ifA.o_resetbAll) lowRunA++;
    else if (lowRunA != 0) begin
      rstRunsA.push_back(lowRunA);
      lowRunA = 0;
    end
    if (ifA.o_busy) busyCycA++;
    prevSclkA = ifA.o_sclk;
    prevSclkB = ifB.o_sclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clearMon();
    capA.delete();
    capB.delete();
    rstRunsA.delete();
    lowRunA  = 0;
    busyCycA = 0;
  endtask

  task automatic applyStimulus(input bit toB, input logic [W-1:0] word);
    if (toB) begin
      ifB.i_cfgword = word;
      ifB.i_start   = 1'b1;
      step(1);
      ifB.i_start   = 1'b0;
    end else begin
      ifA.i_cfgword = word;
      ifA.i_start   = 1'b1;
      step(1);
      ifA.i_start   = 1'b0;
    end
  endtask

  task automatic waitBits(input bit toB, input int n, input int limit);
    int k = 0;
    while ((toB ? capB.size() : capA.size()) < n && k < limit) begin
      step(1);
      k++;
    end
    if ((toB ? capB.size() : capA.size()) < n)
      checkOutput("wait_bits_bound", toB ? capB.size() : capA.size(), n);
  endtask

  task automatic waitEnd(input bit toB, input int limit);
    int k = 0;
    while (!(toB ? (ifB.o_done | ifB.o_error) : (ifA.o_done | ifA.o_error)) && k < limit) begin
      step(1);
      k++;
    end
    if (!(toB ? (ifB.o_done | ifB.o_error) : (ifA.o_done | ifA.o_error)))
      checkOutput("wait_end_bound", toB ? (ifB.o_done | ifB.o_error) : (ifA.o_done | ifA.o_error), 1);
  endtask

  // Reference: a frame of DATA_W MSB-first samples rebuilds the word by shifting
  // in from the right; each attempt is preceded by RSTC reset-low cycles.
  task automatic checkFramesA(input string tag, input logic [W-1:0] word, input int nFrames);
    logic [W-1:0] rec;
    checkOutput({tag, "_bitcount"}, capA.size(), W * nFrames);
    for (int f = 0; f < nFrames; f++) begin
      if (capA.size() >= (f + 1) * W) begin
        rec = '0;
        for (int k = 0; k < W; k++) rec = {rec[W-2:0], capA[f * W + k]};
        checkOutput($sformatf("%s_frame%0d", tag, f), rec, word);
      end
    end
    checkOutput({tag, "_rstruns"}, rstRunsA.size(), nFrames);
    foreach (rstRunsA[i]) checkOutput($sformatf("%s_rstlen%0d", tag, i), rstRunsA[i], RSTC);
  endtask

  task automatic runB(input string tag, input logic [W-1:0] word, input logic [W-1:0] expSeq);
    logic [W-1:0] rec;
    logic [W-1:0] seq;
    clearMon();
    applyStimulus(1'b1, word);
    waitBits(1'b1, W, 200);
    step(3);
    ifB.i_ready = 1'b1;
    waitEnd(1'b1, 100);
    ifB.i_ready = 1'b0;
    checkOutput({tag, "_done"}, {ifB.o_done, ifB.o_error, ifB.o_busy}, 3'b100);
    checkOutput({tag, "_bitcount"}, capB.size(), W);
    if (capB.size() >= W) begin
      rec = '0;
      seq = '0;
      for (int k = 0; k < W; k++) begin
        rec[k] = capB[k];
        seq = {seq[W-2:0], capB[k]};
      end
      checkOutput({tag, "_word"}, rec, word);
      checkOutput({tag, "_seq"}, seq, expSeq);
    end
  endtask

  logic [W-1:0] w1, w2, wr;

  initial begin
    rst = 1'b1;
    ifA.i_start = 1'b0; ifA.i_cfgword = '0; ifA.i_ready = 1'b0;
    ifB.i_start = 1'b0; ifB.i_cfgword = '0; ifB.i_ready = 1'b0;
    step(3);
    // {resetb, sclk, sdout, busy, done, error}
    checkOutput("reset_outs", {ifA.o_resetbAll, ifA.o_sclk, ifA.o_sdout, ifA.o_busy, ifA.o_done, ifA.o_error}, 6'b010000);
    rst = 1'b0;
    step(2);
    checkOutput("idle_outs", {ifA.o_resetbAll, ifA.o_sclk, ifA.o_sdout, ifA.o_busy, ifA.o_done, ifA.o_error}, 6'b110000);

    // Single frame, ready a few cycles into WAIT.
    w1 = 16'($urandom);
    clearMon();
    applyStimulus(1'b0, w1);
    checkOutput("start_latency", {ifA.o_resetbAll, ifA.o_busy, ifA.o_done, ifA.o_error}, 4'b0100);
    waitBits(1'b0, W, 200);
    step(3);
    ifA.i_ready = 1'b1;
    waitEnd(1'b0, 100);
    ifA.i_ready = 1'b0;
    checkOutput("t1_end", {ifA.o_done, ifA.o_error, ifA.o_busy, ifA.o_sclk, ifA.o_sdout, ifA.o_resetbAll}, 6'b100101);
    checkFramesA("t1", w1, 1);

    // LSB-first instance: directed word, then a random one.
    runB("t2_a5c3", 16'hA5C3, 16'hC3A5);
    wr = 16'($urandom);
    runB("t2_rand", wr, {<<{wr}});

    // Ready glitch during SHIFT is ignored; ready arrives on the 2nd attempt.
    w1 = 16'($urandom);
    clearMon();
    applyStimulus(1'b0, w1);
    waitBits(1'b0, 8, 200);
    ifA.i_ready = 1'b1;
    step(3);
    ifA.i_ready = 1'b0;
    waitBits(1'b0, 2 * W, 400);
    step(3);
    ifA.i_ready = 1'b1;
    waitEnd(1'b0, 100);
    ifA.i_ready = 1'b0;
    checkOutput("t4_end", {ifA.o_done, ifA.o_error, ifA.o_busy}, 3'b100);
    checkFramesA("t4", w1, 2);

    // No ready at all: 1 + RETRYA attempts, then ERROR.
    w1 = 16'($urandom);
    clearMon();
    applyStimulus(1'b0, w1);
    waitEnd(1'b0, 1000);
    checkOutput("t3_end", {ifA.o_error, ifA.o_done, ifA.o_busy, ifA.o_sclk, ifA.o_sdout, ifA.o_resetbAll}, 6'b100101);
    checkFramesA("t3", w1, RETRYA + 1);
    checkOutput("t3_busycycles", busyCycA, (RETRYA + 1) * (RSTC + 2 * HP * W + TO));

    // Start during WAIT and a word change mid-SHIFT must not disturb the frame.
    w1 = 16'($urandom);
    w2 = w1 ^ (16'($urandom) | 16'h0001);
    clearMon();
    applyStimulus(1'b0, w1);
    waitBits(1'b0, 4, 200);
    ifA.i_cfgword = w2;
    waitBits(1'b0, W, 200);
    step(4);
    ifA.i_start = 1'b1;
    step(1);
    ifA.i_start = 1'b0;
    checkOutput("t6_no_restart", {ifA.o_resetbAll, ifA.o_busy}, 2'b11);
    ifA.i_ready = 1'b1;
    waitEnd(1'b0, 100);
    ifA.i_ready = 1'b0;
    checkOutput("t6_end", {ifA.o_done, ifA.o_error}, 2'b10);
    checkFramesA("t6_orig", w1, 1);
    clearMon();
    applyStimulus(1'b0, w2);
    waitBits(1'b0, W, 200);
    step(3);
    ifA.i_ready = 1'b1;
    waitEnd(1'b0, 100);
    ifA.i_ready = 1'b0;
    checkFramesA("t6_new", w2, 1);

    // Async reset in the middle of bit 7, then a fresh full frame.
    w1 = 16'($urandom);
    clearMon();
    applyStimulus(1'b0, w1);
    waitBits(1'b0, 7, 200);
    step(1);
    rst = 1'b1;
    #1;
    checkOutput("t5_reset_outs", {ifA.o_resetbAll, ifA.o_sclk, ifA.o_sdout, ifA.o_busy, ifA.o_done, ifA.o_error}, 6'b010000);
    step(1);
    rst = 1'b0;
    step(2);
    w1 = 16'($urandom);
    clearMon();
    applyStimulus(1'b0, w1);
    waitBits(1'b0, W, 200);
    step(3);
    ifA.i_ready = 1'b1;
    waitEnd(1'b0, 100);
    ifA.i_ready = 1'b0;
    checkOutput("t5_end", {ifA.o_done, ifA.o_error}, 2'b10);
    checkFramesA("t5", w1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
